pipe_hazard_ctrl: RTL and testbench
===================================

// Module: pipe_hazard_ctrl
// PURPOSE
// Hazard/stall sequencer for the 5-stage MIPS pipeline. It sits beside the ID-stage
// control decoder and drives the PC, IF/ID, ID/EX and EX/MEM/WB enables.
// It handles load-use stalls, taken-branch/jump squashes, and data-memory wait states
// with a timeout. It sequences the pipeline; it never decodes opcodes itself.
// PARAMETERS
// LU_STALL_CYCLES  1    bubbles inserted per load-use hazard (1..7)
// MEM_TIMEOUT      255  max MEM_WAIT cycles before abort (1..255, 8-bit counter)
// PORTS
// clk          in   1  pipeline clock, rising edge
// rst_n        in   1  asynchronous active-low reset
// id_valid     in   1  IF/ID holds a real instruction
// id_rs        in   5  rs field of instruction in ID
// id_rt        in   5  rt field of instruction in ID
// id_uses_rt   in   1  ID instruction reads rt (R-format, SW, BEQ)
// id_jump      in   1  Jump control of instruction in ID
// ex_mem_read  in   1  MemRead of instruction in EX (ID/EX register)
// ex_rt        in   5  destination rt of instruction in EX
// ex_br_taken  in   1  branch in EX resolved taken (Branch & zero)
// mem_req      in   1  MEM stage is issuing a data access (MemRead|MemWrite)
// mem_ready    in   1  data memory accepts/returns this cycle
// pc_en        out  1  PC register load enable
// ifid_en      out  1  IF/ID register load enable
// ifid_flush   out  1  IF/ID loads NOP (sync clear, higher priority than ifid_en)
// idex_bubble  out  1  ID/EX loads all-zero control (bubble)
// pipe_hold    out  1  hold EX/MEM and MEM/WB registers
// mem_err      out  1  one-cycle pulse: MEM_WAIT timed out
// BEHAVIOUR
// - Outputs are combinational from state+inputs. State and counters are flops on posedge clk.
// - States: RUN, LU_STALL, MEM_WAIT. Reset -> RUN, lu_cnt=0, to_cnt=0.
// - While rst_n=0: pc_en=0, ifid_en=0, ifid_flush=1, idex_bubble=1, pipe_hold=0, mem_err=0.
// - Defaults in RUN (no event): pc_en=1, ifid_en=1, others 0.
// - lu_haz = id_valid & ex_mem_read & ex_rt!=0 & (ex_rt==id_rs | (id_uses_rt & ex_rt==id_rt)).
// - Priority, highest first: mem wait > ex_br_taken > lu_haz > id_jump.
// - Memory wait: mem_req & !mem_ready in RUN or LU_STALL
//   - pc_en=0, ifid_en=0, pipe_hold=1, idex_bubble=0.
//   - -> MEM_WAIT, to_cnt=1.
// - MEM_WAIT:
//   - Holds all stages until mem_ready=1; that cycle releases the hold and applies RUN rules.
//   - Next state RUN. Any pending lu/branch is re-evaluated from live inputs.
//   - to_cnt increments each waiting cycle. At to_cnt==MEM_TIMEOUT with mem_ready=0:
//     mem_err=1 for one cycle, pipe_hold=0, -> RUN (access abandoned).
// - ex_br_taken: pc_en=1 (target loads), ifid_flush=1, idex_bubble=1. Stay in RUN.
//   - Pending load-use stall is cancelled: lu_cnt<=0, LU_STALL->RUN.
// - lu_haz in RUN: pc_en=0, ifid_en=0, idex_bubble=1.
//   - LU_STALL_CYCLES==1: stay RUN; the bubble clears ex_mem_read next cycle.
//   - LU_STALL_CYCLES>1: -> LU_STALL with lu_cnt=LU_STALL_CYCLES-1.
// - LU_STALL:
//   - Same outputs as lu_haz. lu_cnt decrements each cycle; at 0 -> RUN.
// - id_jump (no higher event): pc_en=1, ifid_flush=1 (squash fetched slot), idex_bubble=0.
// - Async reset mid-MEM_WAIT or mid-LU_STALL: immediate return to RUN, counters cleared, no mem_err.
// CONFIGURATION
// HAZ_PERF_CNT_EN defined:
//   - adds outputs stall_cnt[15:0] and flush_cnt[15:0], reset 0, saturating at 16'hFFFF.
//   - stall_cnt +1 per cycle with pc_en=0 (reset excluded).
//   - flush_cnt +1 per cycle with ifid_flush=1 (reset excluded).
// HAZ_PERF_CNT_EN undefined: ports and counters absent; behaviour otherwise identical.
// TESTING
// 1. Reset low 3 cycles, release:
//    - during reset: pc_en=0, ifid_flush=1, idex_bubble=1.
//    - first cycle after release: pc_en=1, ifid_en=1, others 0.
// 2. ex_mem_read=1, ex_rt=8, id_rs=8, id_valid=1:
//    - exactly 1 cycle pc_en=0, ifid_en=0, idex_bubble=1.
//    - same with ex_rt=0 -> no stall.
// 3. ex_br_taken=1 together with lu_haz=1:
//    - pc_en=1, ifid_flush=1, idex_bubble=1.
//    - no stall cycle follows.
// 4. mem_req=1, mem_ready=0 for 4 cycles then 1:
//    - pipe_hold=1, pc_en=0 for 4 cycles.
//    - 5th cycle hold released, state RUN.
// 5. MEM_TIMEOUT=4, mem_ready stuck 0:
//    - mem_err pulses once, 4 cycles after entry; then RUN.
//    - id_jump=1 in RUN -> ifid_flush=1, pc_en=1, idex_bubble=0.
// 6. With HAZ_PERF_CNT_EN, after test 2 + test 3 sequence: stall_cnt=1, flush_cnt=1.

Source files
------------

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: load-use, branch/jump and data-memory wait sequencing.
// Optional macro HAZ_PERF_CNT_EN adds stall_cnt/flush_cnt perf counters.
//
// Inputs : clk, rst_n, ID fields (id_valid, id_rs, id_rt, id_uses_rt,
//          id_jump), EX info (ex_mem_read, ex_rt, ex_br_taken),
//          MEM handshake (mem_req, mem_ready).
// Outputs: pc_en, ifid_en, ifid_flush, idex_bubble, pipe_hold, mem_err
//          (+ stall_cnt, flush_cnt when HAZ_PERF_CNT_EN is defined).
module pipe_hazard_ctrl #(
  parameter int unsigned LU_STALL_CYCLES = 1,
  parameter int unsigned MEM_TIMEOUT     = 255
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       id_valid,
  input  logic [4:0] id_rs,
  input  logic [4:0] id_rt,
  input  logic       id_uses_rt,
  input  logic       id_jump,
  input  logic       ex_mem_read,
  input  logic [4:0] ex_rt,
  input  logic       ex_br_taken,
  input  logic       mem_req,
  input  logic       mem_ready,
  output logic       pc_en,
  output logic       ifid_en,
  output logic       ifid_flush,
  output logic       idex_bubble,
  output logic       pipe_hold,
  output logic       mem_err
`ifdef HAZ_PERF_CNT_EN
  ,
  output logic [15:0] stall_cnt,
  output logic [15:0] flush_cnt
`endif
);

  typedef enum logic [1:0] {
    RUN,
    LU_STALL,
    MEM_WAIT
  } state_t;

  localparam logic [2:0] LU_INIT = 3'(LU_STALL_CYCLES - 1);
  localparam logic [7:0] TO_MAX  = 8'(MEM_TIMEOUT);

  state_t     state_q, state_d;
  logic [2:0] lu_q, lu_d;
  logic [7:0] to_q, to_d;

  logic lu_haz;
  logic in_wait;
  logic timeout;
  logic waiting;
  logic mem_ent;
  logic lu_st;

  assign lu_haz = id_valid & ex_mem_read & (ex_rt != 5'd0)
                & ((ex_rt == id_rs)
                   | (id_uses_rt & (ex_rt == id_rt)));

  assign in_wait = (state_q == MEM_WAIT);
  assign timeout = in_wait & ~mem_ready & (to_q == TO_MAX);
  assign waiting = in_wait & ~mem_ready & ~timeout;
  assign mem_ent = ~in_wait & mem_req & ~mem_ready;
  assign lu_st   = (state_q == LU_STALL);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RUN;
      lu_q    <= '0;
      to_q    <= '0;
    end else begin
      state_q <= state_d;
      lu_q    <= lu_d;
      to_q    <= to_d;
    end
  end

  // Release from MEM_WAIT falls through to the RUN rules below,
  // so a branch or load-use seen that cycle is acted on at once.
  always_comb begin
    state_d     = RUN;
    lu_d        = '0;
    to_d        = '0;
    pc_en       = 1'b1;
    ifid_en     = 1'b1;
    ifid_flush  = 1'b0;
    idex_bubble = 1'b0;
    pipe_hold   = 1'b0;
    mem_err     = 1'b0;
    if (!rst_n) begin
      pc_en       = 1'b0;
      ifid_en     = 1'b0;
      ifid_flush  = 1'b1;
      idex_bubble = 1'b1;
    end else if (timeout) begin
      pc_en   = 1'b0;
      ifid_en = 1'b0;
      mem_err = 1'b1;
    end else if (waiting) begin
      pc_en     = 1'b0;
      ifid_en   = 1'b0;
      pipe_hold = 1'b1;
      state_d   = MEM_WAIT;
      to_d      = to_q + 8'd1;
    end else if (mem_ent) begin
      pc_en     = 1'b0;
      ifid_en   = 1'b0;
      pipe_hold = 1'b1;
      state_d   = MEM_WAIT;
      to_d      = 8'd1;
    end else if (ex_br_taken) begin
      ifid_flush  = 1'b1;
      idex_bubble = 1'b1;
    end else if (lu_st) begin
      pc_en       = 1'b0;
      ifid_en     = 1'b0;
      idex_bubble = 1'b1;
      lu_d        = lu_q - 3'd1;
      if (lu_q != 3'd1) state_d = LU_STALL;
    end else if (lu_haz) begin
      pc_en       = 1'b0;
      ifid_en     = 1'b0;
      idex_bubble = 1'b1;
      if (LU_STALL_CYCLES > 1) begin
        state_d = LU_STALL;
        lu_d    = LU_INIT;
      end
    end else if (id_jump) begin
      ifid_flush = 1'b1;
    end
  end

`ifdef HAZ_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (!pc_en && stall_cnt != 16'hFFFF)
        stall_cnt <= stall_cnt + 16'd1;
      if (ifid_flush && flush_cnt != 16'hFFFF)
        flush_cnt <= flush_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: scoreboard bench for pipe_hazard_ctrl.
// Expected output vectors are queued on drive and compared at negedge.
module tb_pipe_hazard_ctrl;

  typedef struct packed {
    logic       v;
    logic [4:0] rs;
    logic [4:0] rt;
    logic       urt;
    logic       j;
    logic       mr;
    logic [4:0] ert;
    logic       br;
    logic       mq;
    logic       mrdy;
  } in_t;

  typedef struct {
    string      name;
    int         idx;
    logic [5:0] exp;
  } sb_t;

  // {pc_en, ifid_en, ifid_flush, idex_bubble, pipe_hold, mem_err}
  localparam logic [5:0] RUNO = 6'b110000;
  localparam logic [5:0] STL  = 6'b000100;
  localparam logic [5:0] BRO  = 6'b101100;
  localparam logic [5:0] JMP  = 6'b101000;
  localparam logic [5:0] HLD  = 6'b000010;
  localparam logic [5:0] ERR  = 6'b000001;
  localparam logic [5:0] RST  = 6'b001100;

  logic clk;
  logic rst_n;
  in_t  stim;
  logic pc_en, ifid_en, ifid_flush;
  logic idex_bubble, pipe_hold, mem_err;
`ifdef HAZ_PERF_CNT_EN
  logic [15:0] stall_cnt, flush_cnt;
`endif
  logic [5:0] outs;
  sb_t        sb[$];
  int         errors = 0;
  int         checks = 0;

  assign outs = {pc_en, ifid_en, ifid_flush,
                 idex_bubble, pipe_hold, mem_err};

  pipe_hazard_ctrl #(
    .LU_STALL_CYCLES(1),
    .MEM_TIMEOUT(4)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .id_valid(stim.v),
    .id_rs(stim.rs),
    .id_rt(stim.rt),
    .id_uses_rt(stim.urt),
    .id_jump(stim.j),
    .ex_mem_read(stim.mr),
    .ex_rt(stim.ert),
    .ex_br_taken(stim.br),
    .mem_req(stim.mq),
    .mem_ready(stim.mrdy),
    .pc_en(pc_en),
    .ifid_en(ifid_en),
    .ifid_flush(ifid_flush),
    .idex_bubble(idex_bubble),
    .pipe_hold(pipe_hold),
    .mem_err(mem_err)
`ifdef HAZ_PERF_CNT_EN
    ,
    .stall_cnt(stall_cnt),
    .flush_cnt(flush_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  function automatic in_t mk(
    logic v = 0, logic [4:0] rs = 0, logic [4:0] rt = 0,
    logic urt = 0, logic j = 0, logic mr = 0,
    logic [4:0] ert = 0, logic br = 0,
    logic mq = 0, logic mrdy = 1);
    in_t s;
    s = '{v, rs, rt, urt, j, mr, ert, br, mq, mrdy};
    return s;
  endfunction

  // ifid_en is don't-care while ifid_flush overrides it, and the
  // fetch enables are don't-care on the abort cycle.
  function automatic logic [5:0] mask_of(logic [5:0] e);
    if (e == BRO || e == JMP) return 6'b101111;
    if (e == ERR) return 6'b001111;
    return 6'b111111;
  endfunction

  task automatic test_reset();
    in_t st[3];
    sb_t e;
    st = '{mk(), mk(.mq(1), .mrdy(0), .br(1)), mk(.j(1))};
    rst_n = 1'b0;
    stim  = mk();
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      stim = st[i];
      sb.push_back('{"reset", i, RST});
      @(negedge clk);
      e = sb.pop_front();
      checks++;
      if (outs !== e.exp) begin
        errors++;
        $display("FAIL %s[%0d]: got %b want %b",
                 e.name, e.idx, outs, e.exp);
      end
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    stim  = mk();
    sb.push_back('{"reset_rel", 0, RUNO});
    @(negedge clk);
    e = sb.pop_front();
    checks++;
    if (outs !== e.exp) begin
      errors++;
      $display("FAIL %s[%0d]: got %b want %b",
               e.name, e.idx, outs, e.exp);
    end
  endtask

  task automatic test_load_use();
    in_t        st[7];
    logic [5:0] ex[7];
    sb_t        e;
    logic [5:0] m;
    st = '{mk(.v(1), .rs(8), .mr(1), .ert(8)),
           mk(.v(1), .rs(8), .mr(0), .ert(8)),
           mk(.v(1), .rs(0), .mr(1), .ert(0)),
           mk(.v(1), .rs(3), .rt(9), .urt(1), .mr(1), .ert(9)),
           mk(.v(1), .rs(3), .rt(9), .urt(0), .mr(1), .ert(9)),
           mk(.v(0), .rs(8), .mr(1), .ert(8)),
           mk()};
    ex = '{STL, RUNO, RUNO, STL, RUNO, RUNO, RUNO};
    for (int i = 0; i < 7; i++) begin
      @(posedge clk); #1;
      stim = st[i];
      sb.push_back('{"load_use", i, ex[i]});
      @(negedge clk);
      e = sb.pop_front();
      m = mask_of(e.exp);
      checks++;
      if ((outs & m) !== (e.exp & m)) begin
        errors++;
        $display("FAIL %s[%0d]: got %b want %b",
                 e.name, e.idx, outs, e.exp);
      end
    end
  endtask

  task automatic test_branch_jump();
    in_t        st[6];
    logic [5:0] ex[6];
    sb_t        e;
    logic [5:0] m;
    st = '{mk(.v(1), .rs(8), .mr(1), .ert(8), .br(1)),
           mk(.v(0), .rs(8), .mr(1), .ert(8)),
           mk(.v(1), .rs(8), .mr(1), .ert(8), .j(1), .br(1)),
           mk(.v(1), .rs(8), .mr(1), .ert(8), .j(1)),
           mk(.j(1)),
           mk()};
    ex = '{BRO, RUNO, BRO, STL, JMP, RUNO};
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      stim = st[i];
      sb.push_back('{"branch_jump", i, ex[i]});
      @(negedge clk);
      e = sb.pop_front();
      m = mask_of(e.exp);
      checks++;
      if ((outs & m) !== (e.exp & m)) begin
        errors++;
        $display("FAIL %s[%0d]: got %b want %b",
                 e.name, e.idx, outs, e.exp);
      end
    end
  endtask

  task automatic test_mem_wait();
    in_t        st[10];
    logic [5:0] ex[10];
    sb_t        e;
    logic [5:0] m;
    st = '{mk(.mq(1), .mrdy(0)), mk(.mq(1), .mrdy(0)),
           mk(.mq(1), .mrdy(0)), mk(.mq(1), .mrdy(0)),
           mk(.mq(1), .mrdy(1)),
           mk(.mq(1), .mrdy(0), .v(1), .rs(8), .mr(1),
              .ert(8), .br(1)),
           mk(.mq(1), .mrdy(0), .v(1), .rs(8), .mr(1),
              .ert(8), .br(1)),
           mk(.mq(1), .mrdy(1), .v(1), .rs(8), .mr(1), .ert(8)),
           mk(.br(1)),
           mk()};
    ex = '{HLD, HLD, HLD, HLD, RUNO,
           HLD, HLD, STL, BRO, RUNO};
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      stim = st[i];
      sb.push_back('{"mem_wait", i, ex[i]});
      @(negedge clk);
      e = sb.pop_front();
      m = mask_of(e.exp);
      checks++;
      if ((outs & m) !== (e.exp & m)) begin
        errors++;
        $display("FAIL %s[%0d]: got %b want %b",
                 e.name, e.idx, outs, e.exp);
      end
    end
  endtask

  task automatic test_timeout();
    in_t        st[8];
    logic [5:0] ex[8];
    sb_t        e;
    logic [5:0] m;
    st = '{mk(.mq(1), .mrdy(0)), mk(.mq(1), .mrdy(0)),
           mk(.mq(1), .mrdy(0)), mk(.mq(1), .mrdy(0)),
           mk(.mq(1), .mrdy(0)),
           mk(), mk(.j(1)), mk()};
    ex = '{HLD, HLD, HLD, HLD, ERR, RUNO, JMP, RUNO};
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      stim = st[i];
      sb.push_back('{"timeout", i, ex[i]});
      @(negedge clk);
      e = sb.pop_front();
      m = mask_of(e.exp);
      checks++;
      if ((outs & m) !== (e.exp & m)) begin
        errors++;
        $display("FAIL %s[%0d]: got %b want %b",
                 e.name, e.idx, outs, e.exp);
      end
    end
  endtask

  task automatic test_async_reset();
    logic       rs[10];
    logic [5:0] ex[10];
    sb_t        e;
    logic [5:0] m;
    rs = '{1, 1, 1, 0, 1, 1, 1, 1, 1, 1};
    ex = '{HLD, HLD, HLD, RST, HLD,
           HLD, HLD, HLD, ERR, RUNO};
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      rst_n = rs[i];
      stim  = (i < 9) ? mk(.mq(1), .mrdy(0)) : mk();
      sb.push_back('{"async_reset", i, ex[i]});
      @(negedge clk);
      e = sb.pop_front();
      m = mask_of(e.exp);
      checks++;
      if ((outs & m) !== (e.exp & m)) begin
        errors++;
        $display("FAIL %s[%0d]: got %b want %b",
                 e.name, e.idx, outs, e.exp);
      end
    end
  endtask

`ifdef HAZ_PERF_CNT_EN
  task automatic test_perf_cnt();
    in_t st[4];
    st = '{mk(.v(1), .rs(8), .mr(1), .ert(8)),
           mk(),
           mk(.v(1), .rs(8), .mr(1), .ert(8), .br(1)),
           mk()};
    @(posedge clk); #1;
    rst_n = 1'b0;
    stim  = mk();
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (stall_cnt !== 16'd0 || flush_cnt !== 16'd0) begin
      errors++;
      $display("FAIL perf_rst: got %0d/%0d want 0/0",
               stall_cnt, flush_cnt);
    end
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      stim = st[i];
    end
    @(negedge clk);
    checks++;
    if (stall_cnt !== 16'd1) begin
      errors++;
      $display("FAIL perf_stall: got %0d want 1", stall_cnt);
    end
    checks++;
    if (flush_cnt !== 16'd1) begin
      errors++;
      $display("FAIL perf_flush: got %0d want 1", flush_cnt);
    end
  endtask
`endif

  initial begin
    rst_n = 1'b0;
    stim  = mk();
    test_reset();
    test_load_use();
    test_branch_jump();
    test_mem_wait();
    test_timeout();
    test_async_reset();
`ifdef HAZ_PERF_CNT_EN
    test_perf_cnt();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
